m3_cmd_cond: RTL and testbench

Conditions the five raw motor-control buttons before they reach the motoro3 controller. Each button is synchronised and debounced. The block then produces:
- clean one-cycle command pulses,
- a latched rotation-direction level,
- auto-repeating frequency INC/DEC pulses.

It sits directly upstream of motoro3_top, on the clk1Mhz domain, and replaces the raw m3start/m3forceStop/m3invRotate/m3freqINC/m3freqDEC connections.

---
 rtl/m3_cmd_pkg.sv | 24 ++
 rtl/m3_debounce.sv | 51 +++++
 rtl/m3_cmd_cond.sv | 130 +++++++++++++
 tb/tb_m3_cmd_cond.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/m3_cmd_pkg.sv
// Shared encodings and default 1 MHz timing for the motoro3 button conditioner.
package m3_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  typedef enum logic [1:0] {
    KEY_NONE = 2'd0,
    KEY_INC  = 2'd1,
    KEY_DEC  = 2'd2
  } key_e;

  localparam int unsigned DB_CNT_1MHZ  = 10000;
  localparam int unsigned REP_DLY_1MHZ = 500000;
  localparam int unsigned REP_PER_1MHZ = 100000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/m3_debounce.sv
// Synchroniser, debounce counter, stable level and one-cycle press strobe for one button.
module m3_debounce
  import m3_cmd_pkg::*;
#(
  parameter int unsigned DB_CNT  = DB_CNT_1MHZ,
  parameter bit          ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CNT);

  logic          norm;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Internal convention: 1 = pressed.
  assign norm = ACT_LOW ? ~raw : raw;

  // Two-flop sync, then count disagreement cycles; flip the stable state at DB_CNT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CW'(DB_CNT - 1)) begin
          stable <= sync2;
          press  <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/m3_cmd_cond.sv
// Conditions the five motoro3 buttons into command pulses, direction level and auto-repeat INC/DEC.
module m3_cmd_cond
  import m3_cmd_pkg::*;
#(
  parameter int unsigned DB_CNT  = DB_CNT_1MHZ,
  parameter int unsigned REP_DLY = REP_DLY_1MHZ,
  parameter int unsigned REP_PER = REP_PER_1MHZ,
  parameter bit          ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic m3startRaw,
  input  logic m3forceStopRaw,
  input  logic m3invRotateRaw,
  input  logic m3freqINCRaw,
  input  logic m3freqDECRaw,
  output logic m3start,
  output logic m3forceStop,
  output logic m3invRotate,
  output logic m3freqINC,
  output logic m3freqDEC
);

  localparam int unsigned TW_RAW = $clog2(max_u(REP_DLY, REP_PER));
  localparam int unsigned TW     = (TW_RAW == 0) ? 1 : TW_RAW;

  logic start_stable, start_press;
  logic fs_stable, fs_press;
  logic inv_stable, inv_press;
  logic inc_stable, inc_press;
  logic dec_stable, dec_press;

  rep_state_e    state, state_n;
  key_e          held, held_n;
  key_e          key_c;
  logic [TW-1:0] timer, timer_n;
  logic          inc_pulse_c, dec_pulse_c;

  // Levels/strobes that have no consumer in this block.
  logic unused_bits;
  assign unused_bits = ^{start_stable, inv_stable, fs_press};

  m3_debounce #(.DB_CNT(DB_CNT), .ACT_LOW(ACT_LOW)) u_db_start (
    .clk(clk), .rst_n(nRst), .raw(m3startRaw), .stable(start_stable), .press(start_press));
  m3_debounce #(.DB_CNT(DB_CNT), .ACT_LOW(ACT_LOW)) u_db_fs (
    .clk(clk), .rst_n(nRst), .raw(m3forceStopRaw), .stable(fs_stable), .press(fs_press));
  m3_debounce #(.DB_CNT(DB_CNT), .ACT_LOW(ACT_LOW)) u_db_inv (
    .clk(clk), .rst_n(nRst), .raw(m3invRotateRaw), .stable(inv_stable), .press(inv_press));
  m3_debounce #(.DB_CNT(DB_CNT), .ACT_LOW(ACT_LOW)) u_db_inc (
    .clk(clk), .rst_n(nRst), .raw(m3freqINCRaw), .stable(inc_stable), .press(inc_press));
  m3_debounce #(.DB_CNT(DB_CNT), .ACT_LOW(ACT_LOW)) u_db_dec (
    .clk(clk), .rst_n(nRst), .raw(m3freqDECRaw), .stable(dec_stable), .press(dec_press));

  // Exactly one of INC/DEC held selects the key; both or neither means none.
  always_comb begin
    key_c = KEY_NONE;
    if (inc_stable && !dec_stable) begin
      key_c = KEY_INC;
    end else if (dec_stable && !inc_stable) begin
      key_c = KEY_DEC;
    end
  end

  // Repeat FSM: initial pulse, long delay, then periodic pulses while the same key stays held.
  always_comb begin
    state_n     = state;
    held_n      = held;
    timer_n     = timer;
    inc_pulse_c = 1'b0;
    dec_pulse_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inc_press && key_c == KEY_INC) begin
          inc_pulse_c = 1'b1;
          held_n      = KEY_INC;
          timer_n     = TW'(REP_DLY - 1);
          state_n     = ST_HOLD;
        end else if (dec_press && key_c == KEY_DEC) begin
          dec_pulse_c = 1'b1;
          held_n      = KEY_DEC;
          timer_n     = TW'(REP_DLY - 1);
          state_n     = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (key_c != held) begin
          held_n  = KEY_NONE;
          timer_n = '0;
          state_n = ST_IDLE;
        end else if (timer == '0) begin
          inc_pulse_c = (held == KEY_INC);
          dec_pulse_c = (held == KEY_DEC);
          timer_n     = TW'(REP_PER - 1);
          state_n     = ST_REPEAT;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        held_n  = KEY_NONE;
        timer_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM registers and all registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= ST_IDLE;
      held        <= KEY_NONE;
      timer       <= '0;
      m3start     <= 1'b0;
      m3forceStop <= 1'b0;
      m3invRotate <= 1'b0;
      m3freqINC   <= 1'b0;
      m3freqDEC   <= 1'b0;
    end else begin
      state       <= state_n;
      held        <= held_n;
      timer       <= timer_n;
      m3start     <= start_press & ~m3forceStop;
      m3forceStop <= fs_stable;
      m3invRotate <= m3invRotate ^ (inv_press & ~m3forceStop);
      m3freqINC   <= inc_pulse_c;
      m3freqDEC   <= dec_pulse_c;
    end
  end

endmodule

// File: tb/tb_m3_cmd_cond.sv
// Directed bench for m3_cmd_cond with DB_CNT=4, REP_DLY=20, REP_PER=5, active-low buttons.
module tb_m3_cmd_cond;

  logic clk;
  logic nRst;
  logic m3startRaw, m3forceStopRaw, m3invRotateRaw, m3freqINCRaw, m3freqDECRaw;
  logic m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC;

  int n_cmp;
  int n_err;
  int ninc, ndec, nst, finc, fdec, fst, tot_dec;

  m3_cmd_cond #(.DB_CNT(4), .REP_DLY(20), .REP_PER(5), .ACT_LOW(1'b1)) dut (
    .clk(clk), .nRst(nRst),
    .m3startRaw(m3startRaw), .m3forceStopRaw(m3forceStopRaw), .m3invRotateRaw(m3invRotateRaw),
    .m3freqINCRaw(m3freqINCRaw), .m3freqDECRaw(m3freqDECRaw),
    .m3start(m3start), .m3forceStop(m3forceStop), .m3invRotate(m3invRotate),
    .m3freqINC(m3freqINC), .m3freqDEC(m3freqDEC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles sampling at negedge; count pulses and record first sample index (1-based).
  task automatic run(input int n, output int c_inc, output int c_dec, output int c_st,
                     output int f_inc, output int f_dec, output int f_st);
    c_inc = 0; c_dec = 0; c_st = 0; f_inc = 0; f_dec = 0; f_st = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (m3freqINC) begin c_inc++; if (f_inc == 0) f_inc = i; end
      if (m3freqDEC) begin c_dec++; if (f_dec == 0) f_dec = i; end
      if (m3start)   begin c_st++;  if (f_st == 0)  f_st = i;  end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; tot_dec = 0;
    nRst = 1'b0;
    m3startRaw = 1'b1; m3forceStopRaw = 1'b1; m3invRotateRaw = 1'b1;
    m3freqINCRaw = 1'b1; m3freqDECRaw = 1'b1;
    wait_cyc(3);
    chk("rst_start", int'(m3start), 0);
    chk("rst_fs", int'(m3forceStop), 0);
    chk("rst_inv", int'(m3invRotate), 0);
    chk("rst_inc", int'(m3freqINC), 0);
    chk("rst_dec", int'(m3freqDEC), 0);
    nRst = 1'b1;
    run(10, ninc, ndec, nst, finc, fdec, fst);
    chk("idle_pulses", ninc + ndec + nst, 0);

    // 1. bounce rejection then a clean press
    nst = 0;
    for (int k = 0; k < 5; k++) begin
      m3startRaw = 1'b0;
      run(3, ninc, ndec, fst, finc, fdec, fst);
      nst += fst;
      m3startRaw = 1'b1;
      run(3, ninc, ndec, fst, finc, fdec, fst);
      nst += fst;
    end
    wait_cyc(3);
    chk("bounce_start", nst, 0);
    m3startRaw = 1'b0;
    run(10, ninc, ndec, nst, finc, fdec, fst);
    chk("start_count", nst, 1);
    chk("start_lat", fst, 7);
    m3startRaw = 1'b1;
    wait_cyc(10);

    // 2. force-stop gating and direction toggle
    m3forceStopRaw = 1'b0;
    wait_cyc(8);
    chk("fs_level", int'(m3forceStop), 1);
    m3startRaw = 1'b0; m3invRotateRaw = 1'b0;
    run(10, ninc, ndec, nst, finc, fdec, fst);
    chk("fs_gate_start", nst, 0);
    chk("fs_gate_inv", int'(m3invRotate), 0);
    m3startRaw = 1'b1; m3invRotateRaw = 1'b1;
    wait_cyc(10);
    m3forceStopRaw = 1'b1;
    wait_cyc(10);
    chk("fs_release", int'(m3forceStop), 0);
    m3invRotateRaw = 1'b0;
    wait_cyc(20);
    chk("inv_toggle1", int'(m3invRotate), 1);
    m3invRotateRaw = 1'b1;
    wait_cyc(10);
    m3invRotateRaw = 1'b0;
    wait_cyc(8);
    chk("inv_toggle2", int'(m3invRotate), 0);
    m3invRotateRaw = 1'b1;
    wait_cyc(10);

    // 3. auto-repeat: pulses at samples 7, 27, 32, 37, 42, 47, 52
    m3freqINCRaw = 1'b0;
    run(26, ninc, ndec, nst, finc, fdec, fst);
    tot_dec += ndec;
    chk("rep_first_cnt", ninc, 1);
    chk("rep_first_at", finc, 7);
    run(1, ninc, ndec, nst, finc, fdec, fst);
    tot_dec += ndec;
    chk("rep_second", ninc, 1);
    run(29, ninc, ndec, nst, finc, fdec, fst);
    tot_dec += ndec;
    chk("rep_periodic", ninc, 5);
    chk("rep_period_at", finc, 5);
    m3freqINCRaw = 1'b1;
    run(7, ninc, ndec, nst, finc, fdec, fst);
    tot_dec += ndec;
    run(30, ninc, ndec, nst, finc, fdec, fst);
    tot_dec += ndec;
    chk("rep_after_release", ninc, 0);
    chk("rep_dec_quiet", tot_dec, 0);

    // 4. key conflict
    m3freqINCRaw = 1'b0;
    run(33, ninc, ndec, nst, finc, fdec, fst);
    chk("conf_pre", ninc, 3);
    m3freqDECRaw = 1'b0;
    run(27, ninc, ndec, nst, finc, fdec, fst);
    chk("conf_inc_stop", ninc, 1);
    chk("conf_inc_last", finc, 4);
    chk("conf_dec_none", ndec, 0);
    m3freqINCRaw = 1'b1;
    run(20, ninc, ndec, nst, finc, fdec, fst);
    chk("conf_no_dec", ninc + ndec, 0);
    m3freqDECRaw = 1'b1;
    run(10, ninc, ndec, nst, finc, fdec, fst);
    chk("conf_rel_quiet", ninc + ndec, 0);
    m3freqDECRaw = 1'b0;
    run(10, ninc, ndec, nst, finc, fdec, fst);
    chk("conf_dec_repress", ndec, 1);
    chk("conf_dec_at", fdec, 7);
    m3freqDECRaw = 1'b1;
    wait_cyc(30);

    // 5. simultaneous press
    m3freqINCRaw = 1'b0; m3freqDECRaw = 1'b0;
    run(30, ninc, ndec, nst, finc, fdec, fst);
    chk("simul_inc", ninc, 0);
    chk("simul_dec", ndec, 0);
    m3freqINCRaw = 1'b1; m3freqDECRaw = 1'b1;
    wait_cyc(10);

    // 6. reset during REPEAT with direction set
    m3invRotateRaw = 1'b0;
    wait_cyc(8);
    m3invRotateRaw = 1'b1;
    wait_cyc(10);
    chk("pre_rst_inv", int'(m3invRotate), 1);
    m3freqINCRaw = 1'b0;
    wait_cyc(32);
    chk("pre_rst_inc", int'(m3freqINC), 1);
    #2 nRst = 1'b0;
    #1;
    chk("mid_rst_inc", int'(m3freqINC), 0);
    chk("mid_rst_inv", int'(m3invRotate), 0);
    chk("mid_rst_all", int'({m3start, m3forceStop, m3freqDEC}), 0);
    @(negedge clk);
    nRst = 1'b1;
    run(10, ninc, ndec, nst, finc, fdec, fst);
    chk("post_rst_first", finc, 7);
    chk("post_rst_cnt", ninc, 1);
    chk("post_rst_inv", int'(m3invRotate), 0);
    m3freqINCRaw = 1'b1;
    wait_cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
